// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and mem_op bit positions for the memory-access stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 81;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_WD     = 6;
  localparam int MEM_OP_W     = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int MEM_OP_LB  = 4;
  localparam int MEM_OP_LBU = 3;
  localparam int MEM_OP_LH  = 2;
  localparam int MEM_OP_LHU = 1;
  localparam int MEM_OP_LW  = 0;

  typedef struct packed {
    logic [MEM_OP_W-1:0] mem_op;
    logic [31:0]         pc;
    logic                data_ram_en;
    logic [3:0]          data_ram_wen;
    logic                sel_rf_res;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         ex_result;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks byte/halfword/word from the read word,
// sign- or zero-extends it, and flags misaligned halfword/word accesses.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [MEM_OP_W-1:0] i_mem_op,
  input  logic [1:0]          i_addr,
  input  logic [31:0]         i_rdata,
  output logic [31:0]         o_load_res,
  output logic                o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  // mem_op is one-hot; all-zero selects nothing and yields 0
  always_comb begin
    o_load_res = '0;
    if (i_mem_op[MEM_OP_LB])       o_load_res = {{24{w_byte[7]}}, w_byte};
    else if (i_mem_op[MEM_OP_LBU]) o_load_res = {24'd0, w_byte};
    else if (i_mem_op[MEM_OP_LH])  o_load_res = {{16{w_half[15]}}, w_half};
    else if (i_mem_op[MEM_OP_LHU]) o_load_res = {16'd0, w_half};
    else if (i_mem_op[MEM_OP_LW])  o_load_res = i_rdata;
  end

  assign o_misalign = ((i_mem_op[MEM_OP_LH] | i_mem_op[MEM_OP_LHU]) & i_addr[0])
                    | (i_mem_op[MEM_OP_LW] & (|i_addr));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, holds SRAM read data across stalls,
// extracts loads and drives write-back/forwarding buses. Optional alignment check: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic                    adel
);

  ex_mem_t     r_bus;
  logic        r_first;
  logic [31:0] r_rdata_buf;

  logic [31:0] w_rdata_eff;
  logic [31:0] w_load_res;
  logic        w_misalign;
  logic        w_rf_we;
  logic [31:0] w_rf_wdata;

  // Stage register: bubble has priority over capture; otherwise hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus       <= '0;
      r_first     <= 1'b0;
      r_rdata_buf <= '0;
    end else begin
      if (stall[3] == Stop && stall[4] == NoStop) begin
        r_bus   <= '0;
        r_first <= 1'b0;
      end else if (stall[3] == NoStop) begin
        r_bus   <= ex_mem_t'(ex_to_mem_bus);
        r_first <= 1'b1;
      end else begin
        r_first <= 1'b0;
      end
      if (r_first) r_rdata_buf <= data_sram_rdata;
    end
  end

  // SRAM data is only valid in the first cycle; later cycles use the buffered copy
  assign w_rdata_eff = r_first ? data_sram_rdata : r_rdata_buf;

  load_align u_load_align (
    .i_mem_op   (r_bus.mem_op),
    .i_addr     (r_bus.ex_result[1:0]),
    .i_rdata    (w_rdata_eff),
    .o_load_res (w_load_res),
    .o_misalign (w_misalign)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign adel = w_misalign;
  logic w_unused;
  assign w_unused = ^{stall[5], stall[2:0], r_bus.data_ram_en, r_bus.data_ram_wen};
`else
  assign adel = 1'b0;
  logic w_unused;
  assign w_unused = ^{stall[5], stall[2:0], r_bus.data_ram_en, r_bus.data_ram_wen, w_misalign};
`endif

  assign w_rf_we    = r_bus.rf_we & ~adel;
  assign w_rf_wdata = r_bus.sel_rf_res ? w_load_res : r_bus.ex_result;

  assign mem_to_wb_bus = {r_bus.pc, w_rf_we, r_bus.rf_waddr, w_rf_wdata};
  assign mem_to_rf_bus = {w_rf_we, r_bus.rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the instruction held in the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic [80:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        adel;

  int n_cmp = 0;
  int n_bad = 0;

  // model: instruction currently in the stage and the load word it saw on arrival
  logic [80:0] m_bus;
  bit          m_new;
  logic [31:0] m_word;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .adel            (adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc,
                                      input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, |op, 4'b0000, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] addr,
                                           input logic [31:0] word);
    int a = int'(addr);
    int v;
    case (op)
      5'b10000: begin v = int'((word >> (8 * a)) & 32'hFF); if (v >= 128) v -= 256; end
      5'b01000: v = int'((word >> (8 * a)) & 32'hFF);
      5'b00100: begin v = int'((word >> (16 * (a / 2))) & 32'hFFFF); if (v >= 32768) v -= 65536; end
      5'b00010: v = int'((word >> (16 * (a / 2))) & 32'hFFFF);
      5'b00001: v = int'(word);
      default:  v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit ref_misaligned(input logic [4:0] op, input logic [1:0] addr);
    if ((op == 5'b00100 || op == 5'b00010) && addr[0]) return 1'b1;
    if (op == 5'b00001 && addr != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_model();
    logic [4:0]  op;
    logic [31:0] pc, res, wd;
    logic [4:0]  wa;
    logic        sel, we, exp_adel;
    op  = m_bus[80:76];
    pc  = m_bus[75:44];
    sel = m_bus[38];
    we  = m_bus[37];
    wa  = m_bus[36:32];
    res = m_bus[31:0];
`ifdef MEM_ALIGN_CHECK_EN
    exp_adel = ref_misaligned(op, res[1:0]);
`else
    exp_adel = 1'b0;
`endif
    wd = sel ? ref_load(op, res[1:0], m_word) : res;
    check("wb_bus", 128'(mem_to_wb_bus), 128'({pc, we & ~exp_adel, wa, wd}));
    check("rf_bus", 128'(mem_to_rf_bus), 128'({we & ~exp_adel, wa, wd}));
    check("adel", 128'(adel), 128'(exp_adel));
  endtask

  // drive one cycle: inputs set before the edge, SRAM word appears just after it
  task automatic step(input logic [5:0] s, input logic [80:0] b, input logic [31:0] rd);
    stall = s;
    ex_to_mem_bus = b;
    @(posedge clk);
    if (s[3] && !s[4]) begin
      m_bus = '0;
      m_new = 1'b0;
    end else if (!s[3]) begin
      m_bus = b;
      m_new = 1'b1;
    end else begin
      m_new = 1'b0;
    end
    #1 data_sram_rdata = rd;
    @(negedge clk);
    if (m_new) m_word = data_sram_rdata;
    compare_model();
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [80:0] lwb;
    ops[0] = 5'b00000; ops[1] = 5'b00001; ops[2] = 5'b00010;
    ops[3] = 5'b00100; ops[4] = 5'b01000; ops[5] = 5'b10000;
    m_bus = '0; m_new = 1'b0; m_word = '0;
    resetn = 1'b1;
    stall = '0;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    #2 resetn = 1'b0;
    #1;
    check("reset_wb", 128'(mem_to_wb_bus), 128'(0));
    check("reset_rf", 128'(mem_to_rf_bus), 128'(0));
    check("reset_adel", 128'(adel), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    step(6'b000000, mk(5'b10000, 32'h100, 1'b1, 1'b1, 5'd4, 32'h1002), 32'h12803456);
    check("lb", 128'(mem_to_wb_bus[31:0]), 128'(32'hFFFFFF80));
    step(6'b000000, mk(5'b01000, 32'h104, 1'b1, 1'b1, 5'd5, 32'h1002), 32'h12803456);
    check("lbu", 128'(mem_to_wb_bus[31:0]), 128'(32'h00000080));
    step(6'b000000, mk(5'b00100, 32'h108, 1'b1, 1'b1, 5'd6, 32'h1002), 32'h80017FFF);
    check("lh", 128'(mem_to_wb_bus[31:0]), 128'(32'hFFFF8001));
    step(6'b000000, mk(5'b00010, 32'h10C, 1'b1, 1'b1, 5'd7, 32'h1000), 32'h80017FFF);
    check("lhu", 128'(mem_to_wb_bus[31:0]), 128'(32'h00007FFF));

    lwb = mk(5'b00001, 32'h110, 1'b1, 1'b1, 5'd8, 32'h1004);
    step(6'b000000, lwb, 32'hCAFEF00D);
    check("lw_first", 128'(mem_to_rf_bus[31:0]), 128'(32'hCAFEF00D));
    for (int i = 0; i < 3; i++) begin
      step(6'b011000, lwb, 32'hDEADBEEF);
      check("lw_held", 128'(mem_to_rf_bus[31:0]), 128'(32'hCAFEF00D));
    end

    step(6'b001000, mk(5'b00001, 32'h114, 1'b1, 1'b1, 5'd9, 32'h1008), 32'h0BADF00D);
    check("bubble_we", 128'(mem_to_wb_bus[37]), 128'(0));
    check("bubble_pc", 128'(mem_to_wb_bus[69:38]), 128'(0));
    step(6'b000000, mk(5'b00000, 32'h118, 1'b0, 1'b1, 5'd3, 32'h55), 32'h77777777);
    check("alu", 128'(mem_to_wb_bus[31:0]), 128'(32'h55));
    check("alu_we", 128'(mem_to_wb_bus[37]), 128'(1));

    step(6'b000000, mk(5'b00001, 32'h11C, 1'b1, 1'b1, 5'd10, 32'h1001), 32'h01234567);
`ifdef MEM_ALIGN_CHECK_EN
    check("align_adel", 128'(adel), 128'(1));
    check("align_we", 128'(mem_to_wb_bus[37]), 128'(0));
`else
    check("align_adel", 128'(adel), 128'(0));
    check("align_we", 128'(mem_to_wb_bus[37]), 128'(1));
`endif

    // reset between edges while a load is held
    step(6'b000000, lwb, 32'h13572468);
    step(6'b011000, lwb, 32'h99999999);
    #2 resetn = 1'b0;
    #1;
    check("midrst_wb", 128'(mem_to_wb_bus), 128'(0));
    check("midrst_rf", 128'(mem_to_rf_bus), 128'(0));
    m_bus = '0; m_new = 1'b0; m_word = '0;
    #1 resetn = 1'b1;
    step(6'b011000, lwb, 32'h24682468);
    check("midrst_hold", 128'(mem_to_wb_bus), 128'(0));

    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [31:0] res;
      op  = ops[$urandom_range(0, 5)];
      res = $urandom;
      step(6'($urandom),
           mk(op, $urandom, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom),
              5'($urandom), res),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
